// File: rtl/conv_mul_share_arb.sv
// Shared signed A_W x B_W multiplier, round-robin arbitrated across NUM_REQ lanes, tagged results.
// Latency: a transfer at edge k gives out_valid after edge k+LAT-1 (operand stage + LAT-1 product stages).
// Backpressure: out_valid & ~out_ready freezes every stage, including bubbles, and blocks all grants.
// Build option: define CONV_MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module conv_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 16,
  parameter int B_W     = 8,
  parameter int P_W     = 24,   // must equal A_W+B_W
  parameter int LAT     = 2,    // 2..4
  parameter int ID_W    = 2     // 2**ID_W >= NUM_REQ
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        out_id,
  output logic [P_W-1:0]         out_p
);

  localparam int NPS = LAT - 1;  // product register stages after the operand stage

  logic                 stall;
  logic [ID_W-1:0]      ptr;
  logic                 gnt_any;
  logic [ID_W-1:0]      gnt_id;
  logic [NUM_REQ-1:0]   gnt_vec;
  logic signed [A_W-1:0] a_sel;
  logic signed [B_W-1:0] b_sel;

  // Operand stage
  logic                  s1_v;
  logic [ID_W-1:0]       s1_id;
  logic signed [A_W-1:0] s1_a;
  logic signed [B_W-1:0] s1_b;
  logic signed [P_W-1:0] prod;

  // Product stages; the last one is the output register
  logic [NPS-1:0]        pv;
  logic [ID_W-1:0]       pid [NPS];
  logic [P_W-1:0]        pp  [NPS];

  // The whole pipe moves in lockstep: a held output freezes everything behind it.
  assign stall = out_valid & ~out_ready;

  // Grant search: first valid lane starting at ptr, wrapping; nothing granted in reset or stall.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt_vec = '0;
    if (ap_rst_n && !stall) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = (int'(ptr) + off) % NUM_REQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any      = 1'b1;
          gnt_id       = ID_W'(idx);
          gnt_vec[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = gnt_vec;

  // Operand mux for the granted lane.
  assign a_sel = req_a[int'(gnt_id)*A_W +: A_W];
  assign b_sel = req_b[int'(gnt_id)*B_W +: B_W];

`ifdef CONV_MUL_ARB_FIXED_PRIO_EN
  // Fixed priority: search always begins at lane 0, high lanes may starve.
  assign ptr = '0;
`else
  // Round-robin pointer advances past the lane that just transferred.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
    end
  end
`endif

  // Operand stage: capture the granted lane, or a bubble when nobody is valid.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_v  <= 1'b0;
      s1_id <= '0;
      s1_a  <= '0;
      s1_b  <= '0;
    end else if (!stall) begin
      s1_v <= gnt_any;
      if (gnt_any) begin
        s1_id <= gnt_id;
        s1_a  <= a_sel;
        s1_b  <= b_sel;
      end
    end
  end

  // Full-width signed product; both operands are sign-extended so no bits are lost.
  assign prod = P_W'(s1_a) * P_W'(s1_b);

  // Product register chain; stage NPS-1 drives the outputs directly.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pv <= '0;
      for (int j = 0; j < NPS; j++) begin
        pid[j] <= '0;
        pp[j]  <= '0;
      end
    end else if (!stall) begin
      pv[0]  <= s1_v;
      pid[0] <= s1_id;
      pp[0]  <= prod;
      for (int j = 1; j < NPS; j++) begin
        pv[j]  <= pv[j-1];
        pid[j] <= pid[j-1];
        pp[j]  <= pp[j-1];
      end
    end
  end

  assign out_valid = pv[NPS-1];
  assign out_id    = pid[NPS-1];
  assign out_p     = pp[NPS-1];

endmodule

// File: doc/conv_mul_share_arb.md
Name: conv_mul_share_arb

Overview:
- Time-shares one signed 16x8 multiplier among NUM_REQ requesters (conv kernel lanes) using round-robin arbitration.
- A pipelined product path returns each result tagged with the requester index.
- Sits between the conv line-buffer/weight fetch lanes and the accumulator stage.
- Replaces per-lane multipliers when DSP budget is tight.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 16, width of signed operand a.
- B_W, 8, width of signed operand b.
- P_W, 24, product width; must equal A_W+B_W.
- LAT, 2, issue-to-result latency in cycles (2..4); LAT-1 register stages follow the operand stage.
- ID_W, 2, requester tag width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*A_W  packed signed a operands; lane i at [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  packed signed b operands; lane i at [i*B_W +: B_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_id  out  ID_W  index of the requester that produced out_p.
- out_p  out  P_W  signed product a*b.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - All pipeline valid bits are 0; out_valid=0, out_id=0, out_p=0.
  - RR pointer is 0.
  - req_ready is 0 while ap_rst_n=0.
- Stall: stall = out_valid & ~out_ready.
  - While stall=1 every pipeline stage holds, including bubbles, and no grant is issued.
  - There is no bubble collapsing.
- Grant:
  - When stall=0, grant the first requester with req_valid=1 searching from ptr upward, wrapping modulo NUM_REQ.
  - req_ready = grant; combinational from req_valid and out_valid/out_ready.
  - req_valid must not depend on req_ready.
- Transfer occurs on req_valid[i]&req_ready[i].
  - Stage 1 captures req_a[i], req_b[i], tag i, and valid=1.
  - If no requester is valid, stage 1 captures valid=0 (bubble).
- Pointer:
  - On transfer from i, ptr <= (i+1) mod NUM_REQ.
  - No change without a transfer.
- Arithmetic:
  - out_p = $signed(a)*$signed(b), full P_W bits, no truncation or saturation.
  - -32768 * -128 = +4194304 is representable.
- Latency:
  - A transfer at edge k yields out_valid=1 after edge k+LAT-1, counting non-stalled edges only. Equivalently, the result is visible in cycle k+LAT-1.
  - Throughput is one result per cycle when out_ready is held high.
- Ordering: results leave in grant order; out_id matches the granted index.
- Output hold: while stall=1, out_valid, out_id and out_p are stable.
- A requester holding req_valid high without a grant must not change req_a/req_b (upstream rule; not checked).
- Reset mid-operation: in-flight results are discarded and ptr returns to 0; no partial output after reset release.
- Fairness: with all requesters continuously valid, each gets exactly one grant per NUM_REQ transfers.

Optional Feature:
- Macro: CONV_MUL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins.
  - ptr register is removed; search always starts at 0.
  - Starvation of high indices is accepted.
- Undefined: round-robin as above.
- All other timing and latency are identical in both builds.

Test Plan:
- Reset/idle: ap_rst_n=0 for 3 cycles, then idle -> out_valid=0, out_id=0, out_p=0, req_ready=0.
- Single lane, LAT=2: req_valid=4'b0010, a=300, b=-5 -> req_ready=4'b0010; next cycle out_valid=1, out_id=1, out_p=-1500.
- Round-robin: all four valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1; one out_valid per cycle; out_id follows the same order.
- Backpressure: out_ready=0 for 5 cycles with results in flight -> req_ready=0, outputs frozen; on out_ready=1 results resume with no loss or duplication.
- Extremes: a=-32768, b=-128 -> out_p=4194304. a=32767, b=-128 -> out_p=-4194176.
- Reset mid-flight: assert ap_rst_n=0 with 2 results pending -> out_valid=0 immediately; after release, first grant goes to lane 0. Fixed-priority build: lanes 0 and 3 continuously valid -> lane 3 never granted.
